// File: rtl/bep_frame_deframer.sv
// BEP frame deframer: assembles decoded bits MSB-first into bytes, parses
// SYNC / LEN / payload / CRC-8 frames and hands payload bytes to a small
// valid/ready FIFO. Reports completion or an error cause per frame.
module bep_frame_deframer #(
   parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
   parameter int unsigned MAX_LEN    = 16,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned TIMEOUT    = 64
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       bit_valid,
   input  logic       bit_data,
   input  logic       frame_start,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       frame_done,
   output logic       frame_error,
   output logic [2:0] error_code,
   output logic       busy
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(FIFO_DEPTH);
   localparam logic [7:0]    MAX_LEN_C = 8'(MAX_LEN);
   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_HUNT    = 3'd1;
   localparam logic [2:0] S_LEN     = 3'd2;
   localparam logic [2:0] S_PAYLOAD = 3'd3;
   localparam logic [2:0] S_CRC     = 3'd4;

   localparam logic [2:0] E_SYNC     = 3'd1;
   localparam logic [2:0] E_LEN      = 3'd2;
   localparam logic [2:0] E_CRC      = 3'd3;
   localparam logic [2:0] E_TIMEOUT  = 3'd4;
   localparam logic [2:0] E_OVERFLOW = 3'd5;
   localparam logic [2:0] E_RESTART  = 3'd6;

   logic [2:0]    state;
   logic [6:0]    shreg;
   logic [2:0]    bit_cnt;
   logic [7:0]    crc;
   logic [7:0]    len;
   logic [7:0]    byte_cnt;
   logic [TW-1:0] tmo_cnt;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;

   logic       in_frame;
   logic [7:0] byte_val;
   logic       byte_done;
   logic [7:0] crc_next;
   logic       full;
   logic       pop;
   logic       push;
   logic       push_ok;

   // Byte assembly, CRC step and FIFO handshake decode.
   always_comb begin
      in_frame  = (state != S_IDLE);
      byte_val  = {shreg, bit_data};
      // A coincident frame_start discards the bit, so it never completes a byte.
      byte_done = in_frame && bit_valid && !frame_start && (bit_cnt == 3'd7);
      crc_next  = {crc[6:0], 1'b0} ^ ((crc[7] ^ bit_data) ? 8'h07 : 8'h00);
      full      = (count == DEPTH_C);
      pop       = out_valid && out_ready;
      push      = byte_done && (state == S_PAYLOAD);
      push_ok   = push && (!full || pop);
      out_valid = (count != '0);
      out_data  = out_valid ? mem[rd_ptr] : '0;
      busy      = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CRC);
   end

   // Frame parser: state, shifter, CRC, counters and status pulses.
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= S_IDLE;
         shreg       <= '0;
         bit_cnt     <= '0;
         crc         <= '0;
         len         <= '0;
         byte_cnt    <= '0;
         tmo_cnt     <= '0;
         frame_done  <= 1'b0;
         frame_error <= 1'b0;
         error_code  <= '0;
      end else begin
         frame_done  <= 1'b0;
         frame_error <= 1'b0;
         if (frame_start) begin
            if (in_frame) begin
               frame_error <= 1'b1;
               error_code  <= E_RESTART;
            end
            state    <= S_HUNT;
            bit_cnt  <= '0;
            crc      <= '0;
            byte_cnt <= '0;
            tmo_cnt  <= '0;
         end else if (in_frame) begin
            if (bit_valid) begin
               shreg   <= byte_val[6:0];
               bit_cnt <= bit_cnt + 1'b1;
               tmo_cnt <= '0;
               if ((state == S_LEN) || (state == S_PAYLOAD))
                  crc <= crc_next;
               if (byte_done) begin
                  case (state)
                     S_HUNT: begin
                        if (byte_val == SYNC_BYTE) begin
                           state <= S_LEN;
                        end else begin
                           frame_error <= 1'b1;
                           error_code  <= E_SYNC;
                           state       <= S_IDLE;
                        end
                     end
                     S_LEN: begin
                        if ((byte_val != 8'd0) && (byte_val <= MAX_LEN_C)) begin
                           len   <= byte_val;
                           state <= S_PAYLOAD;
                        end else begin
                           frame_error <= 1'b1;
                           error_code  <= E_LEN;
                           state       <= S_IDLE;
                        end
                     end
                     S_PAYLOAD: begin
                        if (!push_ok) begin
                           frame_error <= 1'b1;
                           error_code  <= E_OVERFLOW;
                           state       <= S_IDLE;
                        end else begin
                           byte_cnt <= byte_cnt + 8'd1;
                           if ((byte_cnt + 8'd1) == len)
                              state <= S_CRC;
                        end
                     end
                     S_CRC: begin
                        if (byte_val == crc) begin
                           frame_done <= 1'b1;
                        end else begin
                           frame_error <= 1'b1;
                           error_code  <= E_CRC;
                        end
                        state <= S_IDLE;
                     end
                     default: state <= S_IDLE;
                  endcase
               end
            end else if (tmo_cnt == TMO_LAST) begin
               frame_error <= 1'b1;
               error_code  <= E_TIMEOUT;
               state       <= S_IDLE;
            end else begin
               tmo_cnt <= tmo_cnt + 1'b1;
            end
         end
      end
   end

   // Payload storage; contents need no reset because out_data is gated by out_valid.
   always_ff @(posedge clock) begin
      if (push_ok)
         mem[wr_ptr] <= byte_val;
   end

   // FIFO pointers and occupancy; a push into a full FIFO is legal when a pop frees a slot.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_bep_frame_deframer.sv
// Self-checking bench for bep_frame_deframer: directed frames from the test
// plan plus randomized frames checked against a frame-level reference model.
module tb_bep_frame_deframer;

   localparam logic [7:0] SYNC    = 8'hA5;
   localparam int         MAX_LEN = 16;
   localparam int         TIMEOUT = 64;

   typedef logic [7:0] bytes_t [$];

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       bit_valid = 1'b0;
   logic       bit_data = 1'b0;
   logic       frame_start = 1'b0;
   logic       ready_val = 1'b1;
   logic       rand_ready = 1'b0;
   logic       rnd_ready = 1'b1;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_valid;
   logic       frame_done;
   logic       frame_error;
   logic [2:0] error_code;
   logic       busy;

   assign out_ready = rand_ready ? rnd_ready : ready_val;

   bep_frame_deframer #(
      .SYNC_BYTE (SYNC),
      .MAX_LEN   (MAX_LEN),
      .FIFO_DEPTH(4),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .bit_valid  (bit_valid),
      .bit_data   (bit_data),
      .frame_start(frame_start),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .frame_done (frame_done),
      .frame_error(frame_error),
      .error_code (error_code),
      .busy       (busy)
   );

   always #5 clock = ~clock;

   // Scoreboard: expected bytes in delivery order; monitor records actual pops.
   logic [7:0] exp_mem [0:4095];
   logic [7:0] got_mem [0:4095];
   int exp_wr   = 0;
   int pop_cnt  = 0;
   int cmp_idx  = 0;
   int done_cnt = 0;
   int err_cnt  = 0;
   int both_cnt = 0;
   int n_checks = 0;
   int n_pass   = 0;
   logic [2:0] exp_code = 3'd0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Monitor: record deliveries and status pulses away from the active edge.
   initial forever begin
      @(negedge clock);
      if (out_valid && out_ready) begin
         got_mem[pop_cnt] = out_data;
         pop_cnt++;
      end
      if (frame_done) done_cnt++;
      if (frame_error) err_cnt++;
      if (frame_done && frame_error) both_cnt++;
   end

   // Random consumer back-pressure source.
   initial forever begin
      @(posedge clock);
      #1;
      rnd_ready = ($urandom % 4) != 0;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push_exp(input logic [7:0] v);
      exp_mem[exp_wr] = v;
      exp_wr++;
   endtask

   task automatic compare_pops();
      for (int k = cmp_idx; k < pop_cnt; k++)
         check("payload", got_mem[k], exp_mem[k]);
      cmp_idx = pop_cnt;
   endtask

   task automatic send_bit(input logic b, input int gap);
      bit_valid = 1'b1;
      bit_data  = b;
      tick();
      bit_valid = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic send_byte(input logic [7:0] v, input int gap);
      for (int i = 7; i >= 0; i--) send_bit(v[i], gap);
   endtask

   task automatic pulse_start();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   // Byte-wise CRC-8, poly 0x07, init 0, MSB-first.
   function automatic logic [7:0] crc8_model(input bytes_t d, input int first, input int cnt);
      logic [7:0] c = 8'h00;
      for (int i = first; i < first + cnt; i++) begin
         c = c ^ d[i];
         for (int k = 0; k < 8; k++)
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
      end
      return c;
   endfunction

   // Reference model: classify the frame, queue its payload, send only what the
   // parser will consume, then compare the frame outcome.
   task automatic run_frame(input bytes_t fr, input int gap);
      int res;
      int n;
      int d0;
      int e0;
      if (fr[0] != SYNC) begin
         res = 1; n = 1;
      end else if (fr[1] == 8'd0 || int'(fr[1]) > MAX_LEN) begin
         res = 2; n = 2;
      end else begin
         n = 3 + int'(fr[1]);
         for (int i = 2; i < n - 1; i++) push_exp(fr[i]);
         res = (fr[n-1] == crc8_model(fr, 1, n - 2)) ? 0 : 3;
      end
      d0 = done_cnt;
      e0 = err_cnt;
      pulse_start();
      for (int i = 0; i < n; i++) send_byte(fr[i], gap);
      repeat (3) tick();
      if (res == 0) begin
         check("done_pulse", done_cnt - d0, 1);
         check("no_error", err_cnt - e0, 0);
         check("code_held", error_code, exp_code);
      end else begin
         check("no_done", done_cnt - d0, 0);
         check("error_pulse", err_cnt - e0, 1);
         check("error_code", error_code, res);
         exp_code = 3'(res);
      end
      check("busy_after", busy, 0);
      compare_pops();
   endtask

   initial begin
      bytes_t fr;
      bytes_t pl;
      int n;
      int d0;
      int e0;
      logic [7:0] c;

      // Reset state
      repeat (3) tick();
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_done", frame_done, 0);
      check("rst_error", frame_error, 0);
      check("rst_code", error_code, 0);
      check("rst_busy", busy, 0);
      reset = 1'b0;
      tick();

      // Good frame and bad CRC, strobes 18 cycles apart
      fr = {8'hA5, 8'h01, 8'h42, 8'hDC};
      run_frame(fr, 17);
      check("good_payload", got_mem[pop_cnt-1], 8'h42);
      fr = {8'hA5, 8'h01, 8'h42, 8'hDD};
      run_frame(fr, 17);

      // Bad sync and bad length
      fr = {8'h5A};
      run_frame(fr, 0);
      fr = {8'hA5, 8'h00};
      run_frame(fr, 1);
      fr = {8'hA5, 8'h11};
      run_frame(fr, 0);

      // Timeout: error exactly TIMEOUT cycles after the last strobe
      pulse_start();
      send_byte(SYNC, 1);
      send_bit(1'b1, 0);
      send_bit(1'b0, 0);
      send_bit(1'b1, 0);
      n = 0;
      while (n < 200 && !frame_error) begin
         tick();
         n++;
      end
      check("timeout_cycles", n, TIMEOUT);
      check("timeout_code", error_code, 4);
      exp_code = 3'd4;
      repeat (2) tick();
      check("timeout_busy", busy, 0);

      // Overflow with a stalled consumer
      ready_val = 1'b0;
      pl = {};
      for (int i = 0; i < 5; i++) pl.push_back(8'($urandom));
      e0 = err_cnt;
      pulse_start();
      send_byte(SYNC, 0);
      send_byte(8'h05, 0);
      for (int j = 0; j < 5; j++) begin
         if (j < 4) push_exp(pl[j]);
         send_byte(pl[j], 0);
      end
      repeat (3) tick();
      check("ovf_error", err_cnt - e0, 1);
      check("ovf_code", error_code, 5);
      check("ovf_held_valid", out_valid, 1);
      exp_code = 3'd5;
      ready_val = 1'b1;
      repeat (8) tick();
      compare_pops();
      check("ovf_drain", pop_cnt, exp_wr);

      // Full FIFO with a pop in the push cycle: no overflow
      ready_val = 1'b0;
      fr = {8'h05};
      for (int i = 0; i < 5; i++) fr.push_back(pl[i] ^ 8'h3C);
      c = crc8_model(fr, 0, 6);
      d0 = done_cnt;
      e0 = err_cnt;
      pulse_start();
      send_byte(SYNC, 0);
      send_byte(8'h05, 0);
      for (int j = 0; j < 5; j++) begin
         push_exp(fr[j+1]);
         for (int i = 7; i >= 0; i--) begin
            if (j == 4 && i == 0) ready_val = 1'b1;
            send_bit(fr[j+1][i], 0);
            ready_val = 1'b0;
         end
      end
      send_byte(c, 0);
      repeat (3) tick();
      check("popfull_done", done_cnt - d0, 1);
      check("popfull_noerr", err_cnt - e0, 0);
      ready_val = 1'b1;
      repeat (8) tick();
      compare_pops();
      check("popfull_drain", pop_cnt, exp_wr);

      // Restart mid-payload, coincident with a bit strobe, then a good frame
      e0 = err_cnt;
      pulse_start();
      send_byte(SYNC, 0);
      send_byte(8'h03, 0);
      send_byte(8'h9E, 0);
      push_exp(8'h9E);
      for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
      frame_start = 1'b1;
      bit_valid   = 1'b1;
      bit_data    = 1'b1;
      tick();
      frame_start = 1'b0;
      bit_valid   = 1'b0;
      tick();
      check("restart_error", err_cnt - e0, 1);
      check("restart_code", error_code, 6);
      exp_code = 3'd6;
      fr = {8'h02, 8'h11, 8'hE7};
      c = crc8_model(fr, 0, 3);
      d0 = done_cnt;
      send_byte(SYNC, 2);
      for (int i = 0; i < 3; i++) send_byte(fr[i], 2);
      push_exp(8'h11);
      push_exp(8'hE7);
      send_byte(c, 2);
      repeat (3) tick();
      check("after_restart_done", done_cnt - d0, 1);
      check("after_restart_code", error_code, 6);
      compare_pops();

      // Reset mid-frame
      ready_val = 1'b0;
      pulse_start();
      send_byte(SYNC, 0);
      send_byte(8'h02, 0);
      send_byte(8'h77, 0);
      push_exp(8'h77);
      for (int i = 0; i < 3; i++) send_bit(1'b0, 0);
      check("pre_reset_valid", out_valid, 1);
      reset = 1'b1;
      tick();
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_data", out_data, 0);
      check("mid_rst_done", frame_done, 0);
      check("mid_rst_error", frame_error, 0);
      check("mid_rst_code", error_code, 0);
      check("mid_rst_busy", busy, 0);
      reset = 1'b0;
      exp_wr = pop_cnt;
      exp_code = 3'd0;
      ready_val = 1'b1;
      tick();

      // Randomized frames with random back-pressure
      rand_ready = 1'b1;
      for (int f = 0; f < 30; f++) begin
         int kind;
         int len;
         logic [7:0] b;
         kind = $urandom_range(0, 3);
         fr = {};
         if (kind == 0) begin
            b = 8'($urandom_range(0, 255));
            if (b == SYNC) b = 8'h5A;
            fr.push_back(b);
         end else if (kind == 1) begin
            fr.push_back(SYNC);
            if ($urandom % 2) fr.push_back(8'h00);
            else fr.push_back(8'($urandom_range(MAX_LEN + 1, 255)));
         end else begin
            len = $urandom_range(1, MAX_LEN);
            fr.push_back(SYNC);
            fr.push_back(8'(len));
            for (int i = 0; i < len; i++) fr.push_back(8'($urandom));
            c = crc8_model(fr, 1, len + 1);
            if (kind == 3) c = c ^ 8'($urandom_range(1, 255));
            fr.push_back(c);
         end
         run_frame(fr, $urandom_range(0, 5));
      end
      rand_ready = 1'b0;
      ready_val  = 1'b1;
      repeat (10) tick();
      compare_pops();
      check("final_drain", pop_cnt, exp_wr);
      check("final_out_valid", out_valid, 0);
      check("pulse_exclusive", both_cnt, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/bep_frame_deframer.md
Name: bep_frame_deframer

Overview:
Consumes the decoded bit stream from the Manchester edge-decoding state machine: a one-cycle bit strobe with its data bit, plus a transmission-begin pulse. It assembles bits MSB-first into bytes and parses the BEP frame: SYNC, LEN, LEN payload bytes, CRC-8. Payload bytes go into a small FIFO with a valid/ready interface to the downstream consumer. The block reports per-frame completion or an error code.

Parameters:
SYNC_BYTE, 8'hA5, required first byte of every frame
MAX_LEN, 16, largest legal LEN value; LEN = 0 or LEN > MAX_LEN is an error
FIFO_DEPTH, 4, payload FIFO entries (power of two, >= 2)
TIMEOUT, 64, maximum clock cycles between bit strobes inside a frame before abort

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
bit_valid  in  1  one-cycle strobe: bit_data is a decoded bit
bit_data  in  1  decoded bit value, sampled only when bit_valid=1
frame_start  in  1  one-cycle pulse at start of transmission
out_data  out  8  FIFO head payload byte
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts out_data when out_valid & out_ready
frame_done  out  1  one-cycle pulse: frame received with a good CRC
frame_error  out  1  one-cycle pulse: frame aborted
error_code  out  3  cause, held until next frame_error or frame_done: 1 bad sync, 2 bad len, 3 crc mismatch, 4 timeout, 5 fifo overflow, 6 restart mid-frame
busy  out  1  state is neither IDLE nor HUNT

Behaviour:
- Reset (already decided): reset reset, synchronous, active-high; clock clock. Reset has priority over all inputs. All outputs are 0 after reset; FIFO is emptied; state is IDLE.
- States: IDLE, HUNT, LEN, PAYLOAD, CRC.
- Bit shifter: each bit_valid does shreg <= {shreg[6:0], bit_data} and increments a 3-bit bit counter. The byte is complete on the 8th bit; the counter wraps to 0.
- IDLE: frame_start -> HUNT. Clear the bit counter, CRC (init 8'h00), byte counter and timeout counter. Ignore bit_valid in IDLE.
- HUNT: on byte complete, byte == SYNC_BYTE -> LEN. Otherwise pulse frame_error with code 1 and go to IDLE.
- LEN: on byte complete, fold the byte into the CRC. If 1 <= byte <= MAX_LEN, latch len and go to PAYLOAD. Otherwise raise error code 2 and go to IDLE.
- PAYLOAD: on byte complete, fold into the CRC and push into the FIFO. out_valid rises the cycle after the 8th bit strobe (1-cycle latency). After the len-th byte -> CRC state.
- CRC state: on byte complete, compare with the running CRC. Equal -> frame_done. Unequal -> frame_error code 3. Either way go to IDLE.
- CRC-8: poly 0x07, MSB-first, no reflection, no xorout. Update per bit: c <= {c[6:0],1'b0} ^ ((c[7]^bit) ? 8'h07 : 8'h00).
- Timeout: in HUNT/LEN/PAYLOAD/CRC, the counter clears on each bit_valid and increments otherwise. When it reaches TIMEOUT -> frame_error code 4, go to IDLE.
- FIFO:
  - Push with FIFO full -> byte dropped, frame_error code 5, go to IDLE.
  - Simultaneous push and pop when full is legal; the pop frees the slot, so there is no overflow.
  - Pop occurs when out_valid & out_ready.
  - The FIFO is NOT flushed on frame errors. Already-delivered bytes stand; the consumer discards them on frame_error.
- frame_start while not IDLE -> frame_error code 6 that cycle, then restart directly in HUNT with all counters and the CRC cleared.
- frame_start in the same cycle as bit_valid: the restart wins and the bit is discarded.
- Pulses: at most one of frame_done and frame_error per cycle; each is high exactly one cycle.
- bit_valid may assert on consecutive cycles; no throughput stall on the input side.

Test Plan:
- Good frame: frame_start, then bits of A5 01 42 DC spaced 18 cycles apart -> out_data 8'h42 valid (out_ready=1); frame_done pulses once; error_code unchanged; busy low afterwards.
- Bad CRC: A5 01 42 DD -> 8'h42 delivered; frame_error with error_code=3; no frame_done.
- Bad sync / bad length: first byte 5A -> code 1. A5 00 -> code 2. A5 11 (17 > MAX_LEN) -> code 2.
- Timeout: A5 then 3 bits, then silence -> frame_error code 4 exactly TIMEOUT cycles after the last strobe.
- Overflow: out_ready=0; frame A5 05 + 5 bytes, bits every cycle -> 4 bytes held; 5th push gives code 5. Repeat with out_ready=1 in the 5th push cycle -> no error.
- Restart and reset: frame_start mid-PAYLOAD -> code 6, then a following good frame completes. Reset mid-frame -> all outputs 0 and out_valid=0 the next cycle.
